// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use a shift-add loop over a 2*WIDTH accumulator; DIV/DIVU use
// restoring shift-subtract. Signed ops run on magnitudes, and the sign is
// fixed up in a final FIX cycle that also writes HI/LO and pulses done.
//
// Handshake: start is a one-cycle request that is only looked at in IDLE.
// There is no ready signal. The caller must wait while busy is high, and any
// start raised during that time is dropped. done pulses for exactly one cycle
// in the same cycle that the new HI/LO values first appear.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_q;     // quotient/product must be negated
    logic               r_neg_r;     // dividend was negative (remainder sign)
    logic [WIDTH-1:0]   r_a;         // |rs|: multiplicand or dividend
    logic [WIDTH-1:0]   r_b;         // |rt|: multiplier or divisor
    logic [2*WIDTH-1:0] r_acc;       // mul: {partial, multiplier}; div: {rem, quot}
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Operand capture signals, meaningful only when start is accepted
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;

    // One-iteration next values
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_part;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_next;

    // Sign-corrected results for the FIX cycle
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Work out operand signs and magnitudes. op[0]=0 selects the signed ops.
    always_comb begin
        w_rs_neg = ~op[0] & rs_data[WIDTH-1];
        w_rt_neg = ~op[0] & rt_data[WIDTH-1];
        w_rs_mag = w_rs_neg ? (~rs_data + WIDTH'(1)) : rs_data;
        w_rt_mag = w_rt_neg ? (~rt_data + WIDTH'(1)) : rt_data;
    end

    // Shift-add step: add the multiplicand to the upper half when the low
    // multiplier bit is set, then shift the whole accumulator right by one.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    end

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor only if it fits.
    always_comb begin
        w_div_part = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_ge   = (w_div_part >= {1'b0, r_b});
        w_div_rem  = w_div_ge ? WIDTH'(w_div_part - {1'b0, r_b})
                              : w_div_part[WIDTH-1:0];
        w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
    end

    // Sign correction and the divide-by-zero override, used in FIX.
    // The two signed-division flags are already zero for the unsigned ops.
    always_comb begin
        w_prod = r_neg_q ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
        w_quot = r_acc[WIDTH-1:0];
        w_rem  = r_acc[2*WIDTH-1:WIDTH];
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_b == '0) begin
                // Return rs unchanged in HI: rebuild it from sign and magnitude.
                w_res_lo = '1;
                w_res_hi = r_neg_r ? (~r_a + WIDTH'(1)) : r_a;
            end else begin
                w_res_lo = r_neg_q ? (~w_quot + WIDTH'(1)) : w_quot;
                w_res_hi = r_neg_r ? (~w_rem + WIDTH'(1)) : w_rem;
            end
        end
    end

    // Control FSM with datapath: IDLE -> CALC (WIDTH iterations) -> FIX -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // start takes priority; mthi/mtlo in the same cycle are dropped
                        r_is_div <= op[1];
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
                        r_a      <= w_rs_mag;
                        r_b      <= w_rt_mag;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_rs_mag : w_rt_mag)};
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end else begin
                        if (mthi) r_hi <= rs_data;
                        if (mtlo) r_lo <= rs_data;
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    if (r_cnt == LAST_ITER) begin
                        r_cnt   <= '0;
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit (WIDTH=32): directed cases, then randomized
// operations. Expected HI/LO values come from plain 64-bit arithmetic. A
// monitor compares them on every done pulse.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         mthi;
  logic         mtlo;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];   // expected {hi, lo}
  int             lat_q[$];   // expected cycle of done
  logic [W-1:0]   m_hi = '0;  // architectural HI/LO of the reference model
  logic [W-1:0]   m_lo = '0;
  int             n_cmp = 0;
  int             n_bad = 0;
  logic           prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the architectural result from 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int                ia, ib;
    longint            sa, sb, q, r;
    longint unsigned   ua, ub, uq, ur;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    case (o)
      2'b00: begin q = sa * sb; return q; end
      2'b01: begin uq = ua * ub; return uq; end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;   // 64-bit: -2^31 / -1 = 2^31, whose low word is 0x80000000
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    int          l;
    if (rst_n && done) begin
      check("done_single_cycle", {63'b0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("result_hilo", {hi, lo}, e);
        check("done_latency", 64'(cyc), 64'(l));
      end
    end
    prev_done <= done;
  end

  // ---------------- driver tasks ----------------
  // Issue one op and follow it until done. With disturb=1 the op is issued
  // together with mthi/mtlo, and later a second start plus mthi/mtlo is raised
  // while busy. Both must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit disturb);
    logic [63:0] e;
    logic [31:0] hi_before, lo_before;
    int          busy_n;
    bit          seen;
    e = model(o, a, b);
    hi_before = m_hi;
    lo_before = m_lo;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    mthi = disturb; mtlo = disturb;
    exp_q.push_back(e);
    lat_q.push_back(cyc + W + 2);
    m_hi = e[63:32];
    m_lo = e[31:0];
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      rs_data = $urandom; rt_data = $urandom;   // must not affect the captured operands
      if (disturb && i == 0) check("hilo_hold_on_start", {hi, lo}, {hi_before, lo_before});
      if (disturb && i == 5) begin
        start = 1'b1; op = 2'($urandom_range(0, 3)); mthi = 1'b1; mtlo = 1'b1;
      end
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {63'b0, seen}, 64'd1);
    check("busy_cycles", 64'(busy_n), 64'(W + 1));
  endtask

  task automatic do_mt(input bit h, input bit l, input logic [31:0] v);
    @(negedge clk);
    mthi = h; mtlo = l; rs_data = v; rt_data = $urandom;
    if (h) m_hi = v;
    if (l) m_lo = v;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_hi", 64'(hi), 64'(m_hi));
    check("mt_lo", 64'(lo), 64'(m_lo));
  endtask

  // Start a MULT, pull reset low 10 cycles in, and expect a clean abort
  task automatic reset_mid_op();
    int done_n;
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = $urandom; rt_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("no_done_after_abort", 64'(done_n), 64'd0);
    check("hilo_zero_after_abort", {hi, lo}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, b;
    logic [1:0]  o;
    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    rs_data = '0; rt_data = '0; mthi = 1'b0; mtlo = 1'b0;
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(2'b11, 32'd7,         32'd2,         1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'd5,         32'd0,         1'b0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0,         1'b0);
    do_mt(1'b1, 1'b1, 32'h0000_1234);
    do_mt(1'b1, 1'b0, 32'h0000_ABCD);
    do_mt(1'b0, 1'b1, 32'h5555_0001);
    run_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
    reset_mid_op();
    run_op(2'b01, 32'd2, 32'd3, 1'b0);

    for (int n = 0; n < 28; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: begin a = $urandom_range(0, 20); b = $urandom_range(1, 6); end
        4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) do_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(o, a, b, 1'($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_hilo", {hi, lo}, {m_hi, m_lo});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
